// File: rtl/spi_dc_master_if.sv
// Byte-stream handshake and SPI/D-C pin bundle for spi_dc_master.
// The master modport is the SPI master's view; slave is the byte source and pin observer.
interface spi_dc_master_if;
  logic [7:0] tx_data_in;
  logic       tx_dc_in;
  logic       tx_last_in;
  logic       tx_valid_in;
  logic       tx_ready_out;
  logic       busy_out;
  logic       spi_sclk_out;
  logic       spi_mosi_out;
  logic       spi_cs_n_out;
  logic       dc_out;

  modport master (
    input  tx_data_in, tx_dc_in, tx_last_in, tx_valid_in,
    output tx_ready_out, busy_out, spi_sclk_out, spi_mosi_out, spi_cs_n_out, dc_out
  );

  modport slave (
    output tx_data_in, tx_dc_in, tx_last_in, tx_valid_in,
    input  tx_ready_out, busy_out, spi_sclk_out, spi_mosi_out, spi_cs_n_out, dc_out
  );
endinterface

// File: rtl/spi_dc_master.sv
// SPI mode-0 master with D/C sideband: MSB-first bytes, CS held across same-dc bytes,
// CS released on last byte or dc change. All SPI pins come straight from flops.
module spi_dc_master #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2
) (
  input logic             clk_in,
  input logic             rst_in,
  spi_dc_master_if.master bus
);

  localparam logic [7:0] HalfLoad = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLoad  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StShift, StWait, StHold, StGap} state_e;

  state_e     state_q;
  logic       sclk_q;
  logic       mosi_q;
  logic       cs_n_q;
  logic       dc_q;
  logic [7:0] shreg_q;
  logic       last_q;
  logic       pend_q;
  logic       pend_dc_q;
  logic [7:0] half_cnt_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] gap_cnt_q;

  logic ready_state;
  logic accept;

  assign ready_state = (state_q == StIdle) || (state_q == StWait);
  assign accept      = ready_state && bus.tx_valid_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      dc_q       <= 1'b0;
      shreg_q    <= 8'd0;
      last_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_dc_q  <= 1'b0;
      half_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
      gap_cnt_q  <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle, StWait: begin
          if (accept) begin
            last_q <= bus.tx_last_in;
            if ((state_q == StWait) && (bus.tx_dc_in != dc_q)) begin
              // dc may only move while CS is high: park the byte and close the frame first.
              shreg_q    <= bus.tx_data_in;
              pend_q     <= 1'b1;
              pend_dc_q  <= bus.tx_dc_in;
              half_cnt_q <= HalfLoad;
              state_q    <= StHold;
            end else begin
              shreg_q    <= {bus.tx_data_in[6:0], 1'b0};
              mosi_q     <= bus.tx_data_in[7];
              dc_q       <= bus.tx_dc_in;
              cs_n_q     <= 1'b0;
              sclk_q     <= 1'b0;
              half_cnt_q <= HalfLoad;
              bit_cnt_q  <= 3'd7;
              state_q    <= StShift;
            end
          end
        end

        StShift: begin
          if (half_cnt_q != 8'd0) begin
            half_cnt_q <= half_cnt_q - 8'd1;
          end else begin
            half_cnt_q <= HalfLoad;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt_q != 3'd0) begin
                bit_cnt_q <= bit_cnt_q - 3'd1;
                mosi_q    <= shreg_q[7];
                shreg_q   <= {shreg_q[6:0], 1'b0};
              end else begin
                state_q <= last_q ? StHold : StWait;
              end
            end
          end
        end

        StHold: begin
          if (half_cnt_q != 8'd0) begin
            half_cnt_q <= half_cnt_q - 8'd1;
          end else begin
            cs_n_q    <= 1'b1;
            gap_cnt_q <= GapLoad;
            if (pend_q) begin
              dc_q <= pend_dc_q;
            end
            state_q <= StGap;
          end
        end

        StGap: begin
          if (gap_cnt_q != 8'd0) begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end else if (pend_q) begin
            pend_q     <= 1'b0;
            cs_n_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= shreg_q[7];
            shreg_q    <= {shreg_q[6:0], 1'b0};
            half_cnt_q <= HalfLoad;
            bit_cnt_q  <= 3'd7;
            state_q    <= StShift;
          end else begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.tx_ready_out = ready_state && !rst_in;
  assign bus.busy_out     = (state_q != StIdle);
  assign bus.spi_sclk_out = sclk_q;
  assign bus.spi_mosi_out = mosi_q;
  assign bus.spi_cs_n_out = cs_n_q;
  assign bus.dc_out       = dc_q;

endmodule

// File: tb/tb_spi_dc_master.sv
// Directed bench for spi_dc_master: single frame, burst, dc switch, WAIT stall,
// mid-byte reset and a CLK_DIV sweep, checked against a bus-level SPI slave model.
module tb_spi_dc_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_dc_master_if bus ();
  spi_dc_master_if bus1 ();
  spi_dc_master_if bus7 ();

  spi_dc_master #(.CLK_DIV(2), .CS_GAP(2)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));
  spi_dc_master #(.CLK_DIV(1), .CS_GAP(2)) dut1 (.clk_in(clk), .rst_in(rst), .bus(bus1));
  spi_dc_master #(.CLK_DIV(7), .CS_GAP(2)) dut7 (.clk_in(clk), .rst_in(rst), .bus(bus7));

  // Sweep instances share data inputs; index 0 is CLK_DIV=1, index 1 is CLK_DIV=7.
  logic [7:0] sw_data;
  logic       sw_dc;
  logic       sw_last;
  logic [1:0] sw_valid;
  logic [1:0] sw_ready, sw_sclk, sw_mosi, sw_cs_n;

  assign bus1.tx_data_in  = sw_data;
  assign bus1.tx_dc_in    = sw_dc;
  assign bus1.tx_last_in  = sw_last;
  assign bus1.tx_valid_in = sw_valid[0];
  assign bus7.tx_data_in  = sw_data;
  assign bus7.tx_dc_in    = sw_dc;
  assign bus7.tx_last_in  = sw_last;
  assign bus7.tx_valid_in = sw_valid[1];
  assign sw_ready = {bus7.tx_ready_out, bus1.tx_ready_out};
  assign sw_sclk  = {bus7.spi_sclk_out, bus1.spi_sclk_out};
  assign sw_mosi  = {bus7.spi_mosi_out, bus1.spi_mosi_out};
  assign sw_cs_n  = {bus7.spi_cs_n_out, bus1.spi_cs_n_out};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Slave model on the main DUT, sampled on the falling clock edge.
  logic [8:0] rx_q[$];
  int rise_cnt = 0, lo_cyc = 0, wait_cyc = 0, gap_cyc = 0, cs_rise_cnt = 0, dc_viol = 0;

  initial begin
    logic       prev_sclk, prev_cs_n, prev_dc;
    logic [7:0] rx_sh;
    int         rx_bits;
    prev_sclk = 1'b0;
    prev_cs_n = 1'b1;
    prev_dc   = 1'b0;
    rx_sh     = 8'd0;
    rx_bits   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rx_bits = 0;
      end else if (!bus.spi_cs_n_out) begin
        lo_cyc++;
        if (bus.tx_ready_out) wait_cyc++;
        if (!prev_cs_n && (bus.dc_out !== prev_dc)) dc_viol++;
        if (bus.spi_sclk_out && !prev_sclk) begin
          rise_cnt++;
          rx_sh = {rx_sh[6:0], bus.spi_mosi_out};
          rx_bits++;
          if (rx_bits == 8) begin
            rx_q.push_back({bus.dc_out, rx_sh});
            rx_bits = 0;
          end
        end
      end else begin
        if (!prev_cs_n) begin
          cs_rise_cnt++;
          rx_bits = 0;
        end
        if (!bus.tx_ready_out) gap_cyc++;
      end
      prev_sclk = bus.spi_sclk_out;
      prev_cs_n = bus.spi_cs_n_out;
      prev_dc   = bus.dc_out;
    end
  end

  int b_lo, b_rise, b_wait, b_gap, b_csr;

  task automatic snap();
    b_lo   = lo_cyc;
    b_rise = rise_cnt;
    b_wait = wait_cyc;
    b_gap  = gap_cyc;
    b_csr  = cs_rise_cnt;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offer one byte and return one cycle after the accepting edge, valid still high.
  task automatic push(input string tag, input logic [7:0] d, input logic dc, input logic last);
    bus.tx_data_in  = d;
    bus.tx_dc_in    = dc;
    bus.tx_last_in  = last;
    bus.tx_valid_in = 1'b1;
    for (int i = 0; i < 1000 && !bus.tx_ready_out; i++) tick();
    check_eq({tag, "_ready"}, 32'(bus.tx_ready_out), 32'd1);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000 && !(bus.tx_ready_out && !bus.busy_out); i++) tick();
    check_eq({tag, "_idle"}, {30'd0, bus.tx_ready_out, bus.busy_out}, 32'h2);
  endtask

  task automatic pop_check(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = 'x;
    if (rx_q.size() > 0) got = rx_q.pop_front();
    check_eq(tag, {23'd0, got}, {23'd0, exp});
  endtask

  initial begin
    int n;
    int stall_bad;
    bus.tx_data_in  = 8'd0;
    bus.tx_dc_in    = 1'b0;
    bus.tx_last_in  = 1'b0;
    bus.tx_valid_in = 1'b0;
    sw_data  = 8'd0;
    sw_dc    = 1'b0;
    sw_last  = 1'b0;
    sw_valid = 2'b00;
    rst      = 1'b1;
    repeat (3) tick();

    check_eq("rst_cs_n", 32'(bus.spi_cs_n_out), 32'd1);
    check_eq("rst_sclk", 32'(bus.spi_sclk_out), 32'd0);
    check_eq("rst_mosi", 32'(bus.spi_mosi_out), 32'd0);
    check_eq("rst_dc", 32'(bus.dc_out), 32'd0);
    check_eq("rst_busy", 32'(bus.busy_out), 32'd0);
    check_eq("rst_ready", 32'(bus.tx_ready_out), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_ready", 32'(bus.tx_ready_out), 32'd1);

    // Single command 0xDA: 32 shift + 2 hold cycles low, 2 gap cycles high.
    snap();
    push("t1", 8'hDA, 1'b0, 1'b1);
    bus.tx_valid_in = 1'b0;
    wait_idle("t1");
    check_eq("t1_cs_low", 32'(lo_cyc - b_lo), 32'd34);
    check_eq("t1_gap", 32'(gap_cyc - b_gap), 32'd2);
    check_eq("t1_rises", 32'(rise_cnt - b_rise), 32'd8);
    pop_check("t1_byte", {1'b0, 8'hDA});

    // Burst, same dc: one WAIT cycle between bytes, CS low throughout.
    snap();
    push("t2a", 8'h01, 1'b1, 1'b0);
    push("t2b", 8'h02, 1'b1, 1'b0);
    push("t2c", 8'h03, 1'b1, 1'b1);
    bus.tx_valid_in = 1'b0;
    wait_idle("t2");
    check_eq("t2_cs_low", 32'(lo_cyc - b_lo), 32'd100);
    check_eq("t2_wait", 32'(wait_cyc - b_wait), 32'd2);
    check_eq("t2_rises", 32'(rise_cnt - b_rise), 32'd24);
    check_eq("t2_cs_rise", 32'(cs_rise_cnt - b_csr), 32'd1);
    pop_check("t2_b0", {1'b1, 8'h01});
    pop_check("t2_b1", {1'b1, 8'h02});
    pop_check("t2_b2", {1'b1, 8'h03});

    // dc switch: 0x2C command, then 0xFF data via HOLD and GAP with no second handshake.
    snap();
    push("t3a", 8'h2C, 1'b0, 1'b0);
    push("t3b", 8'hFF, 1'b1, 1'b1);
    bus.tx_valid_in = 1'b0;
    check_eq("t3_hold_dc", 32'(bus.dc_out), 32'd0);
    n = 0;
    for (int i = 0; i < 100 && !bus.spi_cs_n_out; i++) begin
      n++;
      tick();
    end
    check_eq("t3_hold_len", 32'(n), 32'd2);
    check_eq("t3_gap_dc", 32'(bus.dc_out), 32'd1);
    check_eq("t3_gap_ready", 32'(bus.tx_ready_out), 32'd0);
    n = 0;
    for (int i = 0; i < 100 && bus.spi_cs_n_out; i++) begin
      n++;
      tick();
    end
    check_eq("t3_gap_len", 32'(n), 32'd2);
    check_eq("t3_mosi_b7", 32'(bus.spi_mosi_out), 32'd1);
    wait_idle("t3");
    check_eq("t3_rises", 32'(rise_cnt - b_rise), 32'd16);
    check_eq("t3_cs_low", 32'(lo_cyc - b_lo), 32'd69);
    pop_check("t3_cmd", {1'b0, 8'h2C});
    pop_check("t3_data", {1'b1, 8'hFF});

    // Stall in WAIT for 50 cycles with CS low and mosi parked on bit0.
    snap();
    push("t4a", 8'h55, 1'b0, 1'b0);
    bus.tx_valid_in = 1'b0;
    for (int i = 0; i < 200 && !bus.tx_ready_out; i++) tick();
    stall_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(!bus.spi_cs_n_out && !bus.spi_sclk_out && bus.tx_ready_out && bus.spi_mosi_out)) begin
        stall_bad++;
      end
      tick();
    end
    check_eq("t4_stall", 32'(stall_bad), 32'd0);
    push("t4b", 8'hAA, 1'b0, 1'b1);
    bus.tx_valid_in = 1'b0;
    wait_idle("t4");
    check_eq("t4_wait", 32'(wait_cyc - b_wait), 32'd51);
    check_eq("t4_cs_rise", 32'(cs_rise_cnt - b_csr), 32'd1);
    pop_check("t4_b0", {1'b0, 8'h55});
    pop_check("t4_b1", {1'b0, 8'hAA});

    // Reset after the third rising sclk edge of 0xF0.
    snap();
    push("t5a", 8'hF0, 1'b0, 1'b1);
    bus.tx_valid_in = 1'b0;
    for (int i = 0; i < 200 && (rise_cnt - b_rise) < 3; i++) tick();
    check_eq("t5_pre_mosi", 32'(bus.spi_mosi_out), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("t5_cs_n", 32'(bus.spi_cs_n_out), 32'd1);
    check_eq("t5_sclk", 32'(bus.spi_sclk_out), 32'd0);
    check_eq("t5_mosi", 32'(bus.spi_mosi_out), 32'd0);
    check_eq("t5_ready", 32'(bus.tx_ready_out), 32'd0);
    check_eq("t5_busy", 32'(bus.busy_out), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_eq("t5_ready_rel", 32'(bus.tx_ready_out), 32'd1);
    tick();
    snap();
    push("t5b", 8'h81, 1'b0, 1'b1);
    bus.tx_valid_in = 1'b0;
    wait_idle("t5");
    check_eq("t5_rises", 32'(rise_cnt - b_rise), 32'd8);
    pop_check("t5_byte", {1'b0, 8'h81});
    check_eq("t5_no_extra", 32'(rx_q.size()), 32'd0);

    // CLK_DIV sweep on the side instances.
    for (int k = 0; k < 2; k++) begin
      int         div, run, hi_runs, hi_bad, first_lo;
      logic       cur, s;
      logic [7:0] rx;
      string      tg;
      div = (k == 0) ? 1 : 7;
      tg  = (k == 0) ? "t6_div1" : "t6_div7";
      sw_data     = 8'hA5;
      sw_dc       = 1'b0;
      sw_last     = 1'b1;
      sw_valid[k] = 1'b1;
      for (int i = 0; i < 200 && !sw_ready[k]; i++) tick();
      check_eq({tg, "_ready"}, 32'(sw_ready[k]), 32'd1);
      tick();
      sw_valid[k] = 1'b0;
      cur      = sw_sclk[k];
      run      = 1;
      hi_runs  = 0;
      hi_bad   = 0;
      first_lo = -1;
      rx       = 8'd0;
      for (int i = 0; i < 2000 && !sw_cs_n[k]; i++) begin
        tick();
        if (sw_cs_n[k]) break;
        s = sw_sclk[k];
        if (s == cur) begin
          run++;
        end else begin
          if (cur) begin
            hi_runs++;
            if (run != div) hi_bad++;
          end else if (first_lo < 0) begin
            first_lo = run;
          end
          if (s) rx = {rx[6:0], sw_mosi[k]};
          cur = s;
          run = 1;
        end
      end
      check_eq({tg, "_hi_runs"}, 32'(hi_runs), 32'd8);
      check_eq({tg, "_hi_bad"}, 32'(hi_bad), 32'd0);
      check_eq({tg, "_lo_len"}, 32'(first_lo), 32'(div));
      check_eq({tg, "_byte"}, {24'd0, rx}, 32'hA5);
      for (int i = 0; i < 200 && !sw_ready[k]; i++) tick();
      check_eq({tg, "_idle"}, 32'(sw_ready[k]), 32'd1);
    end

    check_eq("dc_stable_cs_low", 32'(dc_viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_dc_master.md
Name: spi_dc_master

Overview:
- SPI mode-0 master with D/C sideband that drives the ws2812_led_controller SPI slave port (spi_sclk, spi_mosi, spi_cs_n, dc) from a byte-stream valid/ready interface.
- Used on-chip as the host-side source for bring-up and self-test of the LED controller, and as a drop-in host model on other boards.
- Sends bytes MSB first. Holds CS low across consecutive bytes that share the same dc value. Deasserts CS on the last byte and on any dc change.

Parameters:
- CLK_DIV, 2: SCLK half-period in clk_in cycles; legal range 1..255.
- CS_GAP, 2: minimum clk_in cycles that CS stays high between frames; legal range 1..255.

Ports:
- clk_in, input, 1: system clock; all logic is on the rising edge.
- rst_in, input, 1: asynchronous active-high reset.
- tx_data_in, input, 8: byte to send.
- tx_dc_in, input, 1: D/C level for this byte (0 = command, 1 = data).
- tx_last_in, input, 1: deassert CS after this byte.
- tx_valid_in, input, 1: byte offered.
- tx_ready_out, output, 1: master can accept a byte this cycle.
- busy_out, output, 1: frame in progress (state not IDLE).
- spi_sclk_out, output, 1: SPI clock; idles low.
- spi_mosi_out, output, 1: SPI data.
- spi_cs_n_out, output, 1: chip select, active low.
- dc_out, output, 1: D/C line to the slave.

Behaviour:
- Reset values: spi_cs_n_out=1, spi_sclk_out=0, spi_mosi_out=0, dc_out=0, busy_out=0, tx_ready_out=0, state=IDLE, counters=0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous); no partial byte is completed.
- All SPI outputs are registered; there is no combinational path from inputs to SPI pins.
- tx_ready_out=1 only in IDLE and WAIT, and only while rst_in is low.
- A transfer occurs when tx_valid_in and tx_ready_out are both 1 on a rising edge. The byte, dc and last are captured into a shift register.
- State IDLE: cs_n=1, sclk=0. On accept, go to SHIFT. In the next cycle: cs_n=0, dc_out=captured dc, mosi=bit7, sclk=0.
- State SHIFT: 8 bit periods of 2*CLK_DIV cycles each.
  - Each period is CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1.
  - mosi changes only when sclk is low, at the start of each bit period (bit7..bit0). The slave samples on the rising sclk edge.
  - After the 8th high phase, sclk returns to 0. Go to HOLD if last=1, otherwise to WAIT.
  - Total SHIFT duration is 16*CLK_DIV cycles.
- State WAIT: cs_n=0, sclk=0, mosi holds bit0, ready=1.
  - Accept with tx_dc_in equal to dc_out: capture, mosi=bit7 next cycle, back to SHIFT. CS stays low; the inter-byte overhead is exactly 1 cycle.
  - Accept with tx_dc_in different from dc_out: capture the byte, set a pending flag, go to HOLD. The new dc is applied only while CS is high.
  - No valid: stay in WAIT indefinitely with CS low.
- State HOLD: CLK_DIV cycles with cs_n=0, sclk=0, then go to GAP.
- State GAP: cs_n=1 for CS_GAP cycles; ready=0.
  - dc_out is updated to the pending dc on the first GAP cycle, if a byte is pending.
  - At the end of GAP: if pending, go to SHIFT (cs_n=0, mosi=bit7) and clear the pending flag; otherwise go to IDLE.
- dc_out otherwise holds its last value while CS is high; it is never changed while cs_n=0.
- Simultaneous tx_valid_in with tx_last_in in WAIT is legal: the byte is sent, then HOLD and GAP follow.
- busy_out=1 in every state except IDLE.
- Counters: half-period counter 8 bits, bit counter 3 bits, gap counter 8 bits. No wrap is permitted beyond the terminal count; reload on each phase.

Test Plan:
- Single command (CLK_DIV=2, CS_GAP=2): 0xDA, dc=0, last=1.
  - Required: cs_n low for 32+2 cycles.
  - mosi sampled at 8 rising sclk edges = 1,1,0,1,1,0,1,0.
  - dc_out=0 throughout; cs_n high for 2 cycles before ready returns; busy_out then drops.
- Burst, same dc: 0x01, 0x02, 0x03 with dc=1, last on the third byte, valid held high.
  - Required: cs_n low continuously; 24 rising edges; exactly 1 sclk-low cycle of WAIT between bytes; dc_out=1.
- dc switch: command 0x2C (dc=0, last=0), then data 0xFF (dc=1).
  - Required: after the first byte, HOLD 2 cycles, cs_n rises, dc_out goes 0 to 1 while cs_n=1.
  - cs_n falls after 2 gap cycles; 0xFF is shifted with no second handshake.
- Stall in WAIT: 0x55 (last=0), then valid low for 50 cycles, then 0xAA (last=1).
  - Required: cs_n stays low with sclk=0 for all 50 cycles; ready=1; the frame completes normally.
- Reset mid-byte: assert rst_in after the 3rd rising sclk edge of 0xF0.
  - Required: in the same cycle, cs_n=1, sclk=0, mosi=0, ready=0.
  - After release, ready=1 and the next byte 0x81 is sent intact.
- Parameter sweep: CLK_DIV=1 and CLK_DIV=7 with byte 0xA5.
  - Required: the sclk half-period measures exactly 1 and 7 cycles; the received byte equals 0xA5.
